weight_skew_buffer: RTL and testbench
=====================================

Name: weight_skew_buffer

Overview:
Parametrised weight staging buffer for the systolic array's column inputs. It holds one independent weight memory per column, written through a host port. On a tile-read command it streams a contiguous window of each memory into the array, with column j delayed j cycles (diagonal skew). Replaces file-preloaded per-column FIFOs with a runtime-loadable, address-windowed, stallable source.

Parameters:
SYS_COLS, 4, number of array columns / memories
W_BITWIDTH, 8, weight word width in bits
DEPTH, 64, words per column memory; power of two, >= 2
AW, $clog2(DEPTH), address width (derived, not overridden)
LW, $clog2(DEPTH+1), tile length width (derived)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe
wr_col  in  $clog2(SYS_COLS)  target column memory
wr_addr  in  AW  write address
wr_data  in  W_BITWIDTH  write data
start  in  1  tile-read command pulse
rd_base  in  AW  first read address, sampled with start
rd_len  in  LW  words per column, sampled with start
stall  in  1  freeze from array back-pressure
busy  out  1  tile in progress
done  out  1  single-cycle tile-complete pulse
o_valid  out  SYS_COLS  per-column data valid
o_data  out  SYS_COLS x W_BITWIDTH  per-column weight

Behaviour:
- Reset: busy=0, done=0, o_valid=0, o_data=0, FSM=IDLE, skew pipeline cleared. Memory contents are not cleared.
- Reset mid-tile aborts immediately. No done is issued. The next start works normally.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with rd_len != 0. start with rd_len == 0 is ignored.
  - rd_len > DEPTH saturates to DEPTH.
  - RUN -> DRAIN after the column-0 read count reaches the latched length.
  - DRAIN -> IDLE once the column SYS_COLS-1 final word has been presented; done pulses in that cycle.
- start while busy is ignored; latched base and length are unaffected.
- Timing, with start accepted at edge T and no stall:
  - busy=1 from T+1 until done.
  - Column-0 read address = base+k for k = 0..len-1, wrapping modulo DEPTH.
  - Memory read latency is 1 cycle, and outputs are registered.
  - o_valid[j] is high for cycles T+2+j .. T+1+j+len, with o_data[j] = mem_j[(base+k) mod DEPTH].
  - done is high in cycle T+SYS_COLS+len+1; busy falls in the same cycle.
  - A start accepted in the done cycle begins a new tile back-to-back.
- Skew: column j's read enable and address are column 0's, delayed j registers. Equivalently, the valid shift chain drives the per-column read enables.
- Stall: while stall=1 all internal state freezes (FSM, counters, skew registers, memory read registers), and o_valid is forced to 0. When stall drops, the stream resumes with no word lost or duplicated. Each stall cycle adds 1 cycle to done. start during stall in IDLE is still accepted.
- Writes:
  - Allowed in any state, including during stall. Each write is 1 cycle.
  - Reads are read-first: a same-cycle write to the address being read returns the old word.
  - wr_col >= SYS_COLS: the write is dropped.

Optional Feature:
Macro WBUF_ZERO_PAD_EN.
- Defined: o_data[j] is 0 in every cycle where o_valid[j]=0, including stall cycles. This gives zero injection for systolic padding.
- Undefined: o_data[j] holds its last value while o_valid[j]=0.

Test Plan:
- SYS_COLS=4, DEPTH=64. Write mem_j[a]=16*j+a for a=0..7, then start base=0 len=4 -> o_valid[0] high T+2..T+5 with data 0,1,2,3; o_valid[3] high T+5..T+8 with data 48..51; done at T+9.
- Wrap-around: base=62 len=4 -> column 0 reads addresses 62,63,0,1 in order; len=70 -> saturates to 64 words per column, done at T+SYS_COLS+65.
- Stall: assert stall for 3 cycles mid-stream -> o_valid=0 during stall, sequence resumes with no gap or repeat, done delayed exactly 3 cycles.
- Boundaries:
  - start with len=0 -> busy stays 0, no done.
  - start while busy -> ignored.
  - start in the done cycle -> second tile back-to-back.
- Hazards:
  - rst asserted mid-RUN -> next cycle all outputs 0, no done; re-start reads the unchanged memory.
  - Write to the address being read -> old value is output.
- WBUF_ZERO_PAD_EN defined -> o_data=0 in every invalid cycle. Undefined -> o_data holds its last value.

Source files
------------

// File: rtl/weight_skew_buffer.sv
// weight_skew_buffer
//   Weight staging buffer for the systolic array's column inputs. There is one
//   independent weight memory per column, and the host loads it through a
//   write port. A tile-read command streams a contiguous, wrapping address
//   window out of every memory. Column j lags column 0 by j cycles, which
//   gives the diagonal skew. Array back-pressure (stall) freezes the whole
//   read pipeline.
//
//   Optional feature: define WBUF_ZERO_PAD_EN to force o_data[j] to zero
//   whenever o_valid[j] is low. Without it, o_data holds its last value.
//
//   Ports
//     clk      rising-edge clock
//     rst      synchronous active-high reset (memories are not cleared)
//     wr_en    host write strobe
//     wr_col   target column memory
//     wr_addr  write address
//     wr_data  write word
//     start    tile-read command pulse
//     rd_base  first read address, sampled with start
//     rd_len   words per column, sampled with start (saturates to DEPTH)
//     stall    freeze request from the array
//     busy     tile in progress
//     done     single-cycle tile-complete pulse
//     o_valid  per-column word valid
//     o_data   per-column weight word
module weight_skew_buffer #(
   parameter int SYS_COLS   = 4,
   parameter int W_BITWIDTH = 8,
   parameter int DEPTH      = 64,
   localparam int AW        = $clog2(DEPTH),
   localparam int LW        = $clog2(DEPTH + 1),
   localparam int CW        = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr_en,
   input  logic [CW-1:0]                        wr_col,
   input  logic [AW-1:0]                        wr_addr,
   input  logic [W_BITWIDTH-1:0]                wr_data,
   input  logic                                 start,
   input  logic [AW-1:0]                        rd_base,
   input  logic [LW-1:0]                        rd_len,
   input  logic                                 stall,
   output logic                                 busy,
   output logic                                 done,
   output logic [SYS_COLS-1:0]                  o_valid,
   output logic [SYS_COLS-1:0][W_BITWIDTH-1:0]  o_data
);

   localparam int SH = (SYS_COLS > 1) ? SYS_COLS - 1 : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state, state_nx;
   logic [AW-1:0]          base_q;
   logic [LW-1:0]          len_q;
   logic [LW-1:0]          cnt_q;
   logic [SYS_COLS-1:0]    vld_p1;
   logic [SYS_COLS-1:0]    en_col;
   logic [AW-1:0]          addr_col [SYS_COLS];
   logic [AW-1:0]          addr_sh  [SH];
   logic [W_BITWIDTH-1:0]  mem      [SYS_COLS][DEPTH];
   logic [W_BITWIDTH-1:0]  data_p1  [SYS_COLS];
   logic                   done_q;
   logic                   accept, last_rd, fin;

   function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
      return (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
   endfunction

   assign accept  = (state == IDLE) && start && (rd_len != '0);
   assign last_rd = (state == RUN) && !stall && ((cnt_q + LW'(1)) == len_q);
   // The final word of the last column sits in its output register and no
   // further enable is coming behind it.
   assign fin     = (state == DRAIN) && !stall && vld_p1[SYS_COLS-1] &&
                    !en_col[SYS_COLS-1];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)  state_nx = RUN;
         RUN:     if (last_rd) state_nx = DRAIN;
         DRAIN:   if (fin)     state_nx = IDLE;
         default:              state_nx = IDLE;
      endcase
   end

   // Column j reuses column 0's enable and address delayed by j registers.
   // The valid register of column j-1 is exactly column 0's enable delayed
   // j cycles, so the valid chain doubles as the enable skew chain.
   always_comb begin
      en_col      = '0;
      en_col[0]   = (state == RUN);
      addr_col[0] = base_q + cnt_q[AW-1:0];
      for (int j = 1; j < SYS_COLS; j++) begin
         en_col[j]   = vld_p1[j-1];
         addr_col[j] = addr_sh[j-1];
      end
   end

   // Host write port; the memories have no reset.
   always_ff @(posedge clk) begin
      for (int j = 0; j < SYS_COLS; j++) begin
         if (wr_en && (wr_col == CW'(j))) mem[j][wr_addr] <= wr_data;
      end
   end

   // ---- stage p0 -> p1: memory read registers and skew chain ----
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         vld_p1 <= '0;
         done_q <= 1'b0;
         for (int j = 0; j < SH; j++)       addr_sh[j] <= '0;
         for (int j = 0; j < SYS_COLS; j++) data_p1[j] <= '0;
      end else begin
         done_q <= fin;
         if (accept) begin
            base_q <= rd_base;
            len_q  <= sat_len(rd_len);
            cnt_q  <= '0;
         end else if ((state == RUN) && !stall) begin
            cnt_q  <= cnt_q + LW'(1);
         end
         if (!stall) begin
            vld_p1 <= en_col;
            for (int j = 0; j < SYS_COLS - 1; j++) addr_sh[j] <= addr_col[j];
            // Read-first: a same-edge host write lands after this read.
            for (int j = 0; j < SYS_COLS; j++) begin
               if (en_col[j]) data_p1[j] <= mem[j][addr_col[j]];
            end
         end
      end
   end

   assign busy    = (state != IDLE);
   assign done    = done_q;
   assign o_valid = vld_p1 & ~{SYS_COLS{stall}};

   always_comb begin
      for (int j = 0; j < SYS_COLS; j++) begin
`ifdef WBUF_ZERO_PAD_EN
         o_data[j] = o_valid[j] ? data_p1[j] : '0;
`else
         o_data[j] = data_p1[j];
`endif
      end
   end

endmodule

// File: tb/tb_weight_skew_buffer.sv
module tb_weight_skew_buffer;

   localparam int C   = 4;
   localparam int W   = 8;
   localparam int D   = 64;
   localparam int AWB = 6;
   localparam int LWB = 7;
   localparam int CWB = 2;
`ifdef WBUF_ZERO_PAD_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst, wr_en, start, stall;
   logic [CWB-1:0]          wr_col;
   logic [AWB-1:0]          wr_addr, rd_base;
   logic [W-1:0]            wr_data;
   logic [LWB-1:0]          rd_len;
   logic                    busy, done;
   logic [C-1:0]            o_valid;
   logic [C-1:0][W-1:0]     o_data;

   logic [W-1:0] mdl       [C][D];
   logic [W-1:0] last_word [C];
   int tests = 0;
   int fails = 0;

   weight_skew_buffer #(.SYS_COLS(C), .W_BITWIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .rd_base(rd_base), .rd_len(rd_len),
      .stall(stall), .busy(busy), .done(done), .o_valid(o_valid), .o_data(o_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Advance to the next cycle (1 time unit after the edge) with idle inputs.
   task automatic next_cycle();
      @(posedge clk); #1;
      rst = 1'b0; wr_en = 1'b0; start = 1'b0; stall = 1'b0;
   endtask

   task automatic clear_last();
      for (int j = 0; j < C; j++) last_word[j] = '0;
   endtask

   task automatic do_write(input int col, input int addr, input logic [W-1:0] data);
      next_cycle();
      wr_en = 1'b1; wr_col = CWB'(col); wr_addr = AWB'(addr); wr_data = data;
      mdl[col][addr] = data;
   endtask

   // One idle cycle: no tile activity, done as expected.
   task automatic idle_cycle(input bit exp_done, input string tag);
      logic [W-1:0] ed;
      next_cycle(); #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
      tests++; if (done !== exp_done) begin fails++; $display("FAIL %s_done: got %b want %b", tag, done, exp_done); end
      tests++; if (o_valid !== '0) begin fails++; $display("FAIL %s_valid: got %b want 0", tag, o_valid); end
      for (int j = 0; j < C; j++) begin
         ed = ZP ? '0 : last_word[j];
         tests++;
         if (o_data[j] !== ed) begin fails++; $display("FAIL %s_data%0d: got %h want %h", tag, j, o_data[j], ed); end
      end
   endtask

   // Issue a tile and check every cycle up to the last busy cycle against the
   // timing rules: with p counting unstalled progress since acceptance,
   // column j carries word k = p-2-j of the window while 0 <= k < len.
   // smode: 0 none, 1 random stall, 2 three stall cycles mid-stream.
   task automatic run_tile(input int base, input int len, input int smode, input bit hazard,
                           input bit ign, input bit chained, output int ncyc);
      logic [W-1:0] snap [C][D];
      int leff, p, s, k;
      bit st, win, ev;
      logic [W-1:0] ed;
      leff = (len > D) ? D : len;
      snap = mdl;
      next_cycle();
      start = 1'b1; rd_base = AWB'(base); rd_len = LWB'(len);
      stall = (smode == 2) || (smode == 1 && $urandom_range(0, 3) == 0);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tile_c0_busy: got %b want 0", busy); end
      tests++; if (done !== chained) begin fails++; $display("FAIL tile_c0_done: got %b want %b", done, chained); end
      p = 1; s = 1;
      while (p <= C + leff && s < 1000) begin
         next_cycle();
         st = (smode == 2) ? (s >= 4 && s <= 6) :
              (smode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         stall = st;
         if (ign && s == 2) begin
            start = 1'b1; rd_base = AWB'($urandom_range(0, D-1)); rd_len = LWB'($urandom_range(1, D));
         end
         if (hazard && p == 2 && !st) begin
            k = (base + 1) % D;
            wr_en = 1'b1; wr_col = '0; wr_addr = AWB'(k); wr_data = ~snap[0][k];
            mdl[0][k] = ~snap[0][k];
         end
         #1;
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL tile_busy s=%0d: got %b want 1", s, busy); end
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL tile_done_early s=%0d: got %b want 0", s, done); end
         for (int j = 0; j < C; j++) begin
            win = (p >= 2 + j) && (p <= 1 + j + leff);
            if (win) last_word[j] = snap[j][(base + p - 2 - j) % D];
            ev = win && !st;
            ed = (ZP && !ev) ? '0 : last_word[j];
            tests++;
            if (o_valid[j] !== ev) begin fails++; $display("FAIL tile_valid%0d s=%0d: got %b want %b", j, s, o_valid[j], ev); end
            tests++;
            if (o_data[j] !== ed) begin fails++; $display("FAIL tile_data%0d s=%0d: got %h want %h", j, s, o_data[j], ed); end
         end
         if (!st) p++;
         s++;
      end
      tests++;
      if (s >= 1000) begin fails++; $display("FAIL tile_bound: cycle budget %0d exhausted", s); end
      ncyc = s;
   endtask

   task automatic test_reset();
      next_cycle(); rst = 1'b1; stall = 1'b0;
      next_cycle(); rst = 1'b1; #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (o_valid !== '0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      tests++; if (o_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", o_data); end
      clear_last();
      idle_cycle(1'b0, "reset_idle");
   endtask

   task automatic test_load();
      for (int j = 0; j < C; j++)
         for (int a = 0; a < D; a++) do_write(j, a, W'($urandom));
      for (int j = 0; j < C; j++)
         for (int a = 0; a < 8; a++) do_write(j, a, W'(16 * j + a));
   endtask

   task automatic test_basic();
      int n;
      run_tile(0, 4, 0, 1'b0, 1'b0, 1'b0, n);
      tests++; if (n !== C + 4 + 1) begin fails++; $display("FAIL basic_done_cycle: got %0d want %0d", n, C + 5); end
      idle_cycle(1'b1, "basic_done");
      idle_cycle(1'b0, "basic_after");
   endtask

   task automatic test_random_tiles();
      int n;
      for (int i = 0; i < 6; i++) begin
         run_tile($urandom_range(0, D-1), $urandom_range(1, 20), 1, 1'b0, 1'b0, 1'b0, n);
         idle_cycle(1'b1, "rand_done");
      end
      idle_cycle(1'b0, "rand_after");
   endtask

   task automatic test_wrap();
      int n;
      run_tile(62, 4, 0, 1'b0, 1'b0, 1'b0, n);
      idle_cycle(1'b1, "wrap_done");
      run_tile($urandom_range(0, D-1), 70, 0, 1'b0, 1'b0, 1'b0, n);
      tests++; if (n !== C + D + 1) begin fails++; $display("FAIL sat_done_cycle: got %0d want %0d", n, C + D + 1); end
      idle_cycle(1'b1, "sat_done");
      idle_cycle(1'b0, "sat_after");
   endtask

   task automatic test_stall();
      int n;
      run_tile($urandom_range(0, D-1), 8, 2, 1'b0, 1'b0, 1'b0, n);
      tests++; if (n !== C + 8 + 1 + 3) begin fails++; $display("FAIL stall_done_cycle: got %0d want %0d", n, C + 12); end
      idle_cycle(1'b1, "stall_done");
      idle_cycle(1'b0, "stall_after");
   endtask

   task automatic test_len_zero();
      next_cycle();
      start = 1'b1; rd_base = AWB'(5); rd_len = '0;
      for (int i = 0; i < 4; i++) idle_cycle(1'b0, "len0");
   endtask

   task automatic test_start_busy();
      int n;
      run_tile($urandom_range(0, D-1), 10, 0, 1'b0, 1'b1, 1'b0, n);
      tests++; if (n !== C + 10 + 1) begin fails++; $display("FAIL busy_start_cycle: got %0d want %0d", n, C + 11); end
      idle_cycle(1'b1, "busy_start_done");
      idle_cycle(1'b0, "busy_start_after");
   endtask

   task automatic test_back_to_back();
      int n;
      run_tile($urandom_range(0, D-1), 5, 0, 1'b0, 1'b0, 1'b0, n);
      run_tile($urandom_range(0, D-1), 3, 0, 1'b0, 1'b0, 1'b1, n);
      idle_cycle(1'b1, "b2b_done");
      idle_cycle(1'b0, "b2b_after");
   endtask

   task automatic test_reset_mid();
      int n, b;
      b = $urandom_range(0, D-1);
      next_cycle();
      start = 1'b1; rd_base = AWB'(b); rd_len = LWB'(10);
      for (int i = 0; i < 3; i++) next_cycle();
      next_cycle(); rst = 1'b1;
      clear_last();
      for (int i = 0; i < C + 12; i++) idle_cycle(1'b0, "rstmid");
      run_tile(b, 10, 0, 1'b0, 1'b0, 1'b0, n);
      idle_cycle(1'b1, "rstmid_redo_done");
   endtask

   task automatic test_read_first();
      int n, b;
      b = $urandom_range(0, D-1);
      run_tile(b, 6, 0, 1'b1, 1'b0, 1'b0, n);
      idle_cycle(1'b1, "rf_done");
      run_tile(b, 6, 0, 1'b0, 1'b0, 1'b0, n);
      idle_cycle(1'b1, "rf_new_done");
      idle_cycle(1'b0, "rf_after");
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; start = 1'b0; stall = 1'b0;
      wr_col = '0; wr_addr = '0; wr_data = '0; rd_base = '0; rd_len = '0;
      clear_last();
      test_reset();
      test_load();
      test_basic();
      test_random_tiles();
      test_wrap();
      test_stall();
      test_len_zero();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      test_read_first();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
